watch_time_counter: RTL and testbench

Binary time-of-day core for the IC watch. Divides the system clock to a 1 Hz tick and keeps seconds (0-59), minutes (0-59) and hours (0-23) as 8-bit binary values. These values feed the downstream binary-to-BCD digit converters directly. A small mode FSM lets the user set hours and minutes using two pre-debounced single-cycle button pulses.

---
 rtl/watch_pkg.sv | 21 ++
 rtl/watch_mod_counter.sv | 27 ++
 rtl/watch_time_counter.sv | 106 ++++++++++
 tb/tb_watch_time_counter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared constants and types for the watch time-of-day core.
package watch_pkg;

   localparam int TW = 8;

   localparam logic [1:0] MODE_RUN      = 2'd0;
   localparam logic [1:0] MODE_SET_HOUR = 2'd1;
   localparam logic [1:0] MODE_SET_MIN  = 2'd2;

   localparam logic [TW-1:0] SEC_MAX  = 8'd59;
   localparam logic [TW-1:0] MIN_MAX  = 8'd59;
   localparam logic [TW-1:0] HOUR_MAX = 8'd23;

   typedef enum logic [1:0] {
      ST_RUN      = MODE_RUN,
      ST_SET_HOUR = MODE_SET_HOUR,
      ST_SET_MIN  = MODE_SET_MIN,
      ST_BAD      = 2'd3
   } mode_e;

endpackage

// File: rtl/watch_mod_counter.sv
// 8-bit modulo-(MAX+1) counter; carry flags the enabled step that wraps.
module watch_mod_counter
   import watch_pkg::*;
#(
   parameter logic [TW-1:0] MAX = 8'd59
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [TW-1:0] value,
   output logic          carry
);

   logic [TW-1:0] r_value;

   // Anything at or above MAX (including corrupted values) wraps to 0.
   always_ff @(posedge clk) begin
      if (rst)
         r_value <= '0;
      else if (en)
         r_value <= (r_value >= MAX) ? '0 : r_value + 1'b1;
   end

   assign value = r_value;
   assign carry = en && (r_value == MAX);

endmodule

// File: rtl/watch_time_counter.sv
// Time-of-day core: 1 Hz prescaler, sec/min/hour cascade and set-mode FSM.
module watch_time_counter
   import watch_pkg::*;
#(
   parameter  int TICKS_PER_SEC = 100000000,
   localparam int PW            = $clog2(TICKS_PER_SEC)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mode_pulse,
   input  logic          inc_pulse,
   output logic [TW-1:0] sec,
   output logic [TW-1:0] min,
   output logic [TW-1:0] hour,
   output logic [1:0]    mode,
   output logic          sec_tick,
   output logic          day_tick
);

   localparam logic [PW-1:0] LP_LAST = PW'(TICKS_PER_SEC - 1);

   mode_e         r_state;
   mode_e         w_state_next;
   logic [PW-1:0] r_presc;
   logic          r_sec_tick;
   logic          r_day_tick;

   logic w_run, w_tick, w_inc, w_sec_rst;
   logic w_min_en, w_hour_en;
   logic w_sec_carry, w_min_carry, w_hour_carry;

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_RUN;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN:      if (mode_pulse) w_state_next = ST_SET_HOUR;
         ST_SET_HOUR: if (mode_pulse) w_state_next = ST_SET_MIN;
         ST_SET_MIN:  if (mode_pulse) w_state_next = ST_RUN;
         default:     w_state_next = ST_RUN;
      endcase
   end

   assign w_run  = (r_state == ST_RUN);
   assign w_tick = w_run && (r_presc == LP_LAST);
   // A mode change in the same cycle swallows the increment.
   assign w_inc  = inc_pulse && !mode_pulse;

   // Leaving SET_MIN restarts the second so the first tick is a full period away.
   assign w_sec_rst = rst || ((r_state == ST_SET_MIN) && mode_pulse);
   assign w_min_en  = (w_run && w_sec_carry) || ((r_state == ST_SET_MIN) && w_inc);
   assign w_hour_en = (w_run && w_min_carry) || ((r_state == ST_SET_HOUR) && w_inc);

   always_ff @(posedge clk) begin
      if (rst || !w_run)
         r_presc <= '0;
      else if (w_tick)
         r_presc <= '0;
      else
         r_presc <= r_presc + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sec_tick <= 1'b0;
         r_day_tick <= 1'b0;
      end else begin
         r_sec_tick <= w_tick;
         r_day_tick <= w_run && w_hour_carry;
      end
   end

   watch_mod_counter #(.MAX(SEC_MAX)) u_sec (
      .clk   (clk),
      .rst   (w_sec_rst),
      .en    (w_tick),
      .value (sec),
      .carry (w_sec_carry)
   );

   watch_mod_counter #(.MAX(MIN_MAX)) u_min (
      .clk   (clk),
      .rst   (rst),
      .en    (w_min_en),
      .value (min),
      .carry (w_min_carry)
   );

   watch_mod_counter #(.MAX(HOUR_MAX)) u_hour (
      .clk   (clk),
      .rst   (rst),
      .en    (w_hour_en),
      .value (hour),
      .carry (w_hour_carry)
   );

   assign mode     = r_state;
   assign sec_tick = r_sec_tick;
   assign day_tick = r_day_tick;

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed bench for watch_time_counter with TICKS_PER_SEC=4.
module tb_watch_time_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mode_pulse = 1'b0;
   logic       inc_pulse = 1'b0;
   logic [7:0] sec, min, hour;
   logic [1:0] mode;
   logic       sec_tick, day_tick;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   watch_time_counter #(.TICKS_PER_SEC(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .mode_pulse (mode_pulse),
      .inc_pulse  (inc_pulse),
      .sec        (sec),
      .min        (min),
      .hour       (hour),
      .mode       (mode),
      .sec_tick   (sec_tick),
      .day_tick   (day_tick)
   );

   typedef struct {
      logic       r, mp, ip;
      logic [7:0] s, m, h;
      logic [1:0] md;
      logic       st, dt;
   } vec_t;

   vec_t tbl[21];

   function automatic vec_t mk(logic r, logic mp, logic ip, int s, int m, int h,
                               int md, logic st, logic dt);
      vec_t v;
      v.r = r; v.mp = mp; v.ip = ip;
      v.s = 8'(s); v.m = 8'(m); v.h = 8'(h); v.md = 2'(md);
      v.st = st; v.dt = dt;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Apply inputs for one clock edge, then sample 1 time unit after it.
   task automatic cyc(input logic r, input logic mp, input logic ip);
      rst = r; mode_pulse = mp; inc_pulse = ip;
      @(posedge clk);
      #1;
   endtask

   task automatic set_time(input int h, input int m);
      cyc(0, 1, 0);
      repeat (h) cyc(0, 0, 1);
      cyc(0, 1, 0);
      repeat (m) cyc(0, 0, 1);
      cyc(0, 1, 0);
   endtask

   initial begin
      int ticks, last, days, nt;

      //            r  mp ip  s  m  h md st dt
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[4]  = mk(0, 0, 1, 1, 0, 0, 0, 1, 0);
      tbl[5]  = mk(0, 1, 0, 1, 0, 0, 1, 0, 0);
      tbl[6]  = mk(0, 0, 1, 1, 0, 1, 1, 0, 0);
      tbl[7]  = mk(0, 0, 1, 1, 0, 2, 1, 0, 0);
      tbl[8]  = mk(0, 0, 0, 1, 0, 2, 1, 0, 0);
      tbl[9]  = mk(0, 0, 0, 1, 0, 2, 1, 0, 0);
      tbl[10] = mk(0, 0, 0, 1, 0, 2, 1, 0, 0);
      tbl[11] = mk(0, 0, 0, 1, 0, 2, 1, 0, 0);
      tbl[12] = mk(0, 1, 0, 1, 0, 2, 2, 0, 0);
      tbl[13] = mk(0, 0, 1, 1, 1, 2, 2, 0, 0);
      tbl[14] = mk(0, 1, 1, 0, 1, 2, 0, 0, 0);
      tbl[15] = mk(0, 0, 0, 0, 1, 2, 0, 0, 0);
      tbl[16] = mk(0, 0, 0, 0, 1, 2, 0, 0, 0);
      tbl[17] = mk(0, 0, 0, 0, 1, 2, 0, 0, 0);
      tbl[18] = mk(0, 0, 0, 1, 1, 2, 0, 1, 0);
      tbl[19] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);
      tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

      #2;
      for (int i = 0; i < 21; i++) begin
         cyc(tbl[i].r, tbl[i].mp, tbl[i].ip);
         chk($sformatf("vec%0d.sec", i),  sec,      tbl[i].s);
         chk($sformatf("vec%0d.min", i),  min,      tbl[i].m);
         chk($sformatf("vec%0d.hour", i), hour,     tbl[i].h);
         chk($sformatf("vec%0d.mode", i), mode,     tbl[i].md);
         chk($sformatf("vec%0d.stk", i),  sec_tick, tbl[i].st);
         chk($sformatf("vec%0d.dtk", i),  day_tick, tbl[i].dt);
         $display("vec %0d: r=%b mp=%b ip=%b -> %0d:%0d:%0d mode=%0d st=%b dt=%b",
                  i, tbl[i].r, tbl[i].mp, tbl[i].ip, hour, min, sec, mode, sec_tick, day_tick);
      end

      // One full minute of free running.
      cyc(1, 0, 0);
      ticks = 0; last = 0; days = 0;
      for (int n = 1; n <= 240; n++) begin
         cyc(0, 0, 0);
         if (day_tick) days++;
         if (sec_tick) begin
            ticks++;
            chk("minute.tick_gap", n - last, 4);
            chk("minute.sec", sec, ticks % 60);
            last = n;
         end
      end
      chk("minute.ticks", ticks, 60);
      chk("minute.sec_end", sec, 0);
      chk("minute.min_end", min, 1);
      chk("minute.hour_end", hour, 0);
      chk("minute.day_ticks", days, 0);
      $display("minute run: ticks=%0d time=%0d:%0d:%0d", ticks, hour, min, sec);

      // Setting with wrap: 25 hour incs and 61 minute incs, no strobes.
      cyc(1, 0, 0);
      cyc(0, 1, 0);
      repeat (25) cyc(0, 0, 1);
      chk("set.hour_wrap", hour, 1);
      chk("set.mode_hour", mode, 1);
      cyc(0, 1, 0);
      nt = 0;
      for (int n = 0; n < 61; n++) begin
         cyc(0, 0, 1);
         if (sec_tick || day_tick) nt++;
      end
      chk("set.min_wrap", min, 1);
      chk("set.hour_kept", hour, 1);
      chk("set.sec_frozen", sec, 0);
      chk("set.no_strobes", nt, 0);
      $display("set run: time=%0d:%0d:%0d mode=%0d", hour, min, sec, mode);
      cyc(0, 1, 0);
      chk("set.exit_mode", mode, 0);

      // Reset while in SET_HOUR at 13:27:02.
      cyc(1, 0, 0);
      set_time(13, 27);
      repeat (10) cyc(0, 0, 0);
      chk("rst.pre_sec", sec, 2);
      cyc(0, 1, 0);
      chk("rst.pre_mode", mode, 1);
      chk("rst.pre_hour", hour, 13);
      chk("rst.pre_min", min, 27);
      cyc(1, 0, 0);
      chk("rst.sec", sec, 0);
      chk("rst.min", min, 0);
      chk("rst.hour", hour, 0);
      chk("rst.mode", mode, 0);
      chk("rst.strobes", {30'd0, sec_tick, day_tick}, 0);
      $display("reset in set: time=%0d:%0d:%0d mode=%0d", hour, min, sec, mode);

      // inc_pulse held high in RUN must not disturb the count.
      cyc(1, 0, 0);
      for (int k = 1; k <= 10; k++) begin
         cyc(0, 0, 1);
         chk($sformatf("inc_run%0d.sec", k), sec, k / 4);
         chk($sformatf("inc_run%0d.stk", k), sec_tick, (k % 4 == 0) ? 1 : 0);
         chk($sformatf("inc_run%0d.hm", k), {hour, min}, 0);
      end
      $display("inc held in run: time=%0d:%0d:%0d", hour, min, sec);

      // Day rollover from 23:59 preset.
      cyc(1, 0, 0);
      set_time(23, 59);
      chk("day.preset_hour", hour, 23);
      chk("day.preset_min", min, 59);
      days = 0;
      for (int n = 1; n <= 240; n++) begin
         cyc(0, 0, 0);
         if (day_tick) days++;
         if (n == 232) chk("day.sec58", sec, 58);
         if (n == 239) begin
            chk("day.pre_sec", sec, 59);
            chk("day.pre_min", min, 59);
            chk("day.pre_hour", hour, 23);
         end
      end
      chk("day.sec", sec, 0);
      chk("day.min", min, 0);
      chk("day.hour", hour, 0);
      chk("day.sec_tick", sec_tick, 1);
      chk("day.day_tick", day_tick, 1);
      chk("day.count", days, 1);
      $display("rollover: time=%0d:%0d:%0d st=%b dt=%b", hour, min, sec, sec_tick, day_tick);
      cyc(0, 0, 0);
      chk("day.dt_single", day_tick, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
